jump_target_encoder: RTL
========================

# jump_target_encoder

Splits a 16-bit absolute jump target into the instruction words the processor core can execute. It is the encode side of the jump-address path: the core's target formation rebuilds an address as {PC[15:12], Imm[11:0]}, and this block produces words that rebuild to the requested target. It sits between the program loader / code generator and instruction memory write-back. It emits one near-jump word when the target lies in the current 4 KiB region, otherwise a two-word far sequence, over a valid/ready stream.

## Interface
- JUMP_OPCODE, 4'hC, opcode of near jump (12-bit immediate, upper 4 bits from PC)
- LUI_OPCODE, 4'hA, opcode loading an 8-bit immediate into the accumulator's upper byte
- JR_OPCODE, 4'hB, opcode jumping to {accumulator[15:8], imm8}
- CNT_W, 8, width of the statistics counters

- CLK  in  1  system clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- In_Valid  in  1  request valid
- In_Ready  out  1  block can accept a request
- Target  in  16  absolute jump target address
- Cur_PC  in  16  address the first emitted word will occupy
- Out_Valid  out  1  Out_Word valid
- Out_Ready  in  1  downstream accepts Out_Word
- Out_Word  out  16  encoded instruction word
- Out_Last  out  1  Out_Word is the final word of the sequence
- Out_Far  out  1  current sequence is a far jump
- Near_Count  out  CNT_W  near sequences completed, saturating
- Far_Count  out  CNT_W  far sequences completed, saturating

## Operation
- FSM states: IDLE, NEAR, FAR_HI, FAR_LO.
- IDLE behaviour:
  - In_Ready=1 and Out_Valid=0.
  - A request is accepted when In_Valid and In_Ready are both 1 at a rising edge. Target is latched.
  - Near test at accept: Target[15:12] == Cur_PC[15:12]. On a match, go to NEAR; otherwise go to FAR_HI.
- NEAR:
  - Out_Word={JUMP_OPCODE, Target[11:0]}, Out_Last=1, Out_Far=0.
  - On Out_Ready: go to IDLE and increment Near_Count.
- FAR_HI:
  - Out_Word={LUI_OPCODE, 4'h0, Target[15:8]}, Out_Last=0, Out_Far=1.
  - On Out_Ready: go to FAR_LO.
- FAR_LO:
  - Out_Word={JR_OPCODE, 4'h0, Target[7:0]}, Out_Last=1, Out_Far=1.
  - On Out_Ready: go to IDLE and increment Far_Count.
- In_Ready is 1 only in IDLE. In_Valid, Target and Cur_PC are ignored in every other state.
- Counters saturate at 2^CNT_W-1 and never wrap.
- All outputs are registered. In_Ready is decoded from the state register only.

## Timing
- Reset (RST_n=0, takes effect immediately, no clock needed):
  - state=IDLE, Out_Valid=0, Out_Word=16'h0000, Out_Last=0, Out_Far=0.
  - Near_Count=0, Far_Count=0, In_Ready=1.
- Latency:
  - Accept at edge k gives Out_Valid=1 in the cycle after edge k.
  - Near throughput: 1 request per 2 cycles with Out_Ready held 1.
  - Far throughput: 1 request per 3 cycles with Out_Ready held 1.
- Backpressure: while Out_Valid=1 and Out_Ready=0, Out_Word, Out_Last, Out_Far and the state hold unchanged.
- Out_Ready while Out_Valid=0 has no effect.
- A counter increments on the same edge as the final word's handshake.
- Reset mid-sequence drops the sequence with no partial count. The first accept after RST_n rises needs a full clock edge.
- Boundary cases:
  - Target equal to Cur_PC is near.
  - Target[15:12] differing from Cur_PC[15:12] by exactly one region (e.g. 16'h3FFF vs 16'h4000) is far.

## Test plan
All cases use default parameters.
- Near: Cur_PC=16'h4010, Target=16'h4567, Out_Ready=1.
  - Required: one word 16'hC567, Out_Last=1, Out_Far=0, Out_Valid for exactly 1 cycle, Near_Count=1.
- Far: Cur_PC=16'h4010, Target=16'h9ABC.
  - Required: 16'hA09A (Last=0) then 16'hB0BC (Last=1), both with Out_Far=1, Far_Count=1.
- Backpressure: in the far case, hold Out_Ready=0 for 5 cycles in FAR_HI while driving In_Valid=1 with Target=16'h1234.
  - Required: Out_Word held at 16'hA09A, In_Ready=0, the 16'h1234 request is not accepted.
  - After release: 16'hB0BC, then In_Ready=1.
- Region edges, Cur_PC=16'h4000:
  - Target=16'h4FFF gives 16'hCFFF, near.
  - Target=16'h3FFF gives 16'hA03F, 16'hB0FF, far.
- Reset mid-op: assert RST_n=0 asynchronously (between clock edges) while in FAR_LO.
  - Required: Out_Valid=0 and Out_Word=16'h0000 immediately, counters=0.
  - After release: In_Ready=1 and no stale word emitted.
- Saturation: 300 back-to-back far requests with Out_Ready=1.
  - Required: Far_Count=255 and Near_Count=0.

Source files
------------

// File: rtl/jump_target_encoder_if.sv
`default_nettype none
// ============================================================================
// jump_target_encoder_if
// Request/response stream bundle for the jump target encoder.
// Revision: 1.0
// ============================================================================
interface jump_target_encoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      target;
  logic [15:0]      cur_pc;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_word;
  logic             out_last;
  logic             out_far;
  logic [CNT_W-1:0] near_count;
  logic [CNT_W-1:0] far_count;

  modport master (
    output in_valid, target, cur_pc, out_ready,
    input  in_ready, out_valid, out_word, out_last, out_far, near_count, far_count
  );

  modport slave (
    input  in_valid, target, cur_pc, out_ready,
    output in_ready, out_valid, out_word, out_last, out_far, near_count, far_count
  );
endinterface
`default_nettype wire

// File: rtl/jump_target_encoder.sv
`default_nettype none
// ============================================================================
// jump_target_encoder
// Splits a 16-bit jump target into a near jump or a LUI/JR far sequence.
// Revision: 1.0
// ============================================================================
module jump_target_encoder #(
  parameter int         CNT_W       = 8,
  parameter logic [3:0] JUMP_OPCODE = 4'hC,
  parameter logic [3:0] LUI_OPCODE  = 4'hA,
  parameter logic [3:0] JR_OPCODE   = 4'hB
) (
  input  logic                 clk,
  input  logic                 rst_n,
  jump_target_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NEAR   = 2'd1,
    FAR_HI = 2'd2,
    FAR_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_target_lo, w_target_lo_nxt;
  logic             r_valid, w_valid_nxt;
  logic [15:0]      r_word, w_word_nxt;
  logic             r_last, w_last_nxt;
  logic             r_far, w_far_nxt;
  logic [CNT_W-1:0] r_near_count, r_far_count;
  logic             w_near_inc, w_far_inc;
  logic             w_is_near;
  logic             w_unused;

  // Only the region nibble of the PC matters; the core supplies the rest.
  assign w_is_near = (bus.target[15:12] == bus.cur_pc[15:12]);
  assign w_unused  = ^bus.cur_pc[11:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_target_lo  <= 8'h00;
      r_valid      <= 1'b0;
      r_word       <= 16'h0000;
      r_last       <= 1'b0;
      r_far        <= 1'b0;
      r_near_count <= '0;
      r_far_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_target_lo <= w_target_lo_nxt;
      r_valid     <= w_valid_nxt;
      r_word      <= w_word_nxt;
      r_last      <= w_last_nxt;
      r_far       <= w_far_nxt;
      if (w_near_inc && (r_near_count != C_CNT_MAX)) r_near_count <= r_near_count + C_CNT_ONE;
      if (w_far_inc && (r_far_count != C_CNT_MAX))   r_far_count  <= r_far_count + C_CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_target_lo_nxt = r_target_lo;
    w_valid_nxt     = r_valid;
    w_word_nxt      = r_word;
    w_last_nxt      = r_last;
    w_far_nxt       = r_far;
    w_near_inc      = 1'b0;
    w_far_inc       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_target_lo_nxt = bus.target[7:0];
          w_valid_nxt     = 1'b1;
          if (w_is_near) begin
            w_state_nxt = NEAR;
            w_word_nxt  = {JUMP_OPCODE, bus.target[11:0]};
            w_last_nxt  = 1'b1;
            w_far_nxt   = 1'b0;
          end else begin
            w_state_nxt = FAR_HI;
            w_word_nxt  = {LUI_OPCODE, 4'h0, bus.target[15:8]};
            w_last_nxt  = 1'b0;
            w_far_nxt   = 1'b1;
          end
        end
      end
      NEAR: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_near_inc  = 1'b1;
        end
      end
      FAR_HI: begin
        if (bus.out_ready) begin
          w_state_nxt = FAR_LO;
          w_word_nxt  = {JR_OPCODE, 4'h0, r_target_lo};
          w_last_nxt  = 1'b1;
        end
      end
      FAR_LO: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = 1'b0;
          w_far_nxt   = 1'b0;
          w_far_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = (r_state == IDLE);
  assign bus.out_valid  = r_valid;
  assign bus.out_word   = r_word;
  assign bus.out_last   = r_last;
  assign bus.out_far    = r_far;
  assign bus.near_count = r_near_count;
  assign bus.far_count  = r_far_count;

endmodule
`default_nettype wire
